// File: rtl/rs_write_arbiter.sv
// rs_write_arbiter: round-robin share of one rs_write_decodifier between two requesters, with a settle wait and a held, source-tagged result
module rs_write_arbiter #(
  parameter int WIDTH = 12,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [WIDTH-1:0] dec_in,
  input  logic [WIDTH-1:0] dec_out,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_src,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  localparam logic [3:0] SC = 4'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE = 1;
  state_t           r_state;
  logic             r_last;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_dec_in;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_src;
  logic             r_res_valid;
  logic [CNT_W-1:0] r_done;
  logic             w_g1;
  assign w_g1       = req1_valid && (!req0_valid || !r_last);
  assign req0_ready = (r_state == IDLE) && req0_valid && !w_g1;
  assign req1_ready = (r_state == IDLE) && w_g1;
  assign dec_in     = r_dec_in;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_src    = r_res_src;
  assign busy       = r_state != IDLE;
  assign done_count = r_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_dec_in    <= '0;
      r_res_data  <= '0;
      r_res_src   <= 1'b0;
      r_res_valid <= 1'b0;
      r_done      <= '0;
    end else begin
      case (r_state)
        IDLE: if (req0_ready || req1_ready) begin
          r_dec_in  <= w_g1 ? req1_data : req0_data;
          r_res_src <= w_g1;
          r_last    <= w_g1;
          r_cnt     <= SC;
          r_state   <= SETTLE;
        end
        SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_res_data  <= dec_out;
            r_res_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: if (res_ready) begin
          r_res_valid <= 1'b0;
          r_done      <= r_done + ONE;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rs_write_arbiter.sv
// tb_rs_write_arbiter: directed and randomized checks of rs_write_arbiter against an inverting decoder stub
module tb_rs_write_arbiter;
  localparam int W = 12;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic r0v = 0, r1v = 0, rr = 0, r0r, r1r, rv, rs, busy, ovr = 0;
  logic [W-1:0] r0d = 0, r1d = 0, din, dout, rd, stub = 0;
  logic [7:0] dc;
  logic b_r0v = 0, b_r1v = 0, b_rr = 0, b_r0r, b_r1r, b_rv, b_rs, b_busy;
  logic [W-1:0] b_r0d = 0, b_r1d = 0, b_din, b_dout, b_rd;
  logic [7:0] b_dc;
  assign dout   = ovr ? stub : ~din;
  assign b_dout = ~b_din;
  rs_write_arbiter #(.WIDTH(W), .SETTLE_CYCLES(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0r),
    .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1r),
    .dec_in(din), .dec_out(dout),
    .res_valid(rv), .res_data(rd), .res_src(rs), .res_ready(rr),
    .busy(busy), .done_count(dc)
  );
  rs_write_arbiter #(.WIDTH(W), .SETTLE_CYCLES(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(b_r0v), .req0_data(b_r0d), .req0_ready(b_r0r),
    .req1_valid(b_r1v), .req1_data(b_r1d), .req1_ready(b_r1r),
    .dec_in(b_din), .dec_out(b_dout),
    .res_valid(b_rv), .res_data(b_rd), .res_src(b_rs), .res_ready(b_rr),
    .busy(b_busy), .done_count(b_dc)
  );
  int tests = 0;
  int fails = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  bit infl, resv, last, src, e0, e1, hs, keep;
  int age, hs_cnt, cyc;
  logic [W-1:0] word, rdx;
  initial begin
    tick();
    tick();
    chk("rst_res_valid", rv, 0);
    chk("rst_res_data", rd, 0);
    chk("rst_res_src", rs, 0);
    chk("rst_dec_in", din, 0);
    chk("rst_done", dc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_b_busy", b_busy, 0);
    rst = 0;
    rr = 1;
    r0v = 1;
    r0d = 12'hA5C;
    #1;
    chk("t1_r0_ready", r0r, 1);
    chk("t1_r1_ready", r1r, 0);
    tick();
    r0v = 0;
    chk("t1_busy_a", busy, 1);
    chk("t1_dec_in", din, 12'hA5C);
    chk("t1_r0_ready_drop", r0r, 0);
    chk("t1_rv_early", rv, 0);
    tick();
    chk("t1_rv", rv, 1);
    chk("t1_rd", rd, 12'h5A3);
    chk("t1_rs", rs, 0);
    chk("t1_busy_b", busy, 1);
    tick();
    chk("t1_rv_done", rv, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_done", dc, 1);
    chk("t1_dec_in_kept", din, 12'hA5C);
    rst = 1;
    tick();
    rst = 0;
    r0v = 1;
    r1v = 1;
    r0d = 12'h001;
    r1d = 12'h002;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("tie_r0_ready", r0r, (k % 2) == 0);
      chk("tie_r1_ready", r1r, (k % 2) == 1);
      tick();
      tick();
      chk("tie_rv", rv, 1);
      chk("tie_rd", rd, (k % 2) ? 12'hFFD : 12'hFFE);
      chk("tie_rs", rs, k % 2);
      tick();
    end
    chk("tie_done", dc, 4);
    r0v = 0;
    r1v = 0;
    tick();
    rr = 0;
    r0v = 1;
    r1v = 1;
    r0d = 12'h123;
    #1;
    chk("bp_r0_ready", r0r, 1);
    tick();
    tick();
    chk("bp_rv", rv, 1);
    chk("bp_rd", rd, 12'hEDC);
    ovr = 1;
    stub = 12'h000;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_rv", rv, 1);
      chk("bp_hold_rd", rd, 12'hEDC);
      chk("bp_hold_rs", rs, 0);
      chk("bp_no_ready", {r0r, r1r}, 0);
      chk("bp_busy", busy, 1);
    end
    rr = 1;
    tick();
    chk("bp_release_rv", rv, 0);
    chk("bp_done", dc, 5);
    ovr = 0;
    r0v = 0;
    r1v = 0;
    b_rr = 1;
    b_r1v = 1;
    b_r1d = 12'h0F0;
    #1;
    chk("lat_r1_ready", b_r1r, 1);
    tick();
    b_r1v = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("lat_rv", b_rv, i == 3);
    end
    chk("lat_rd", b_rd, 12'hF0F);
    chk("lat_rs", b_rs, 1);
    tick();
    chk("lat_done", b_dc, 1);
    b_r0v = 1;
    b_r0d = 12'h0AB;
    #1;
    chk("mid_r0_ready", b_r0r, 1);
    tick();
    b_r1v = 1;
    b_r1d = 12'h0CD;
    chk("mid_din", b_din, 12'h0AB);
    tick();
    chk("mid_busy", b_busy, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_busy_rst", b_busy, 0);
    chk("mid_rv_rst", b_rv, 0);
    chk("mid_din_rst", b_din, 0);
    chk("mid_done_rst", b_dc, 0);
    #1;
    chk("mid_tie_r0", b_r0r, 1);
    chk("mid_tie_r1", b_r1r, 0);
    b_r0v = 0;
    b_r1v = 0;
    infl = 0;
    resv = 0;
    last = 1;
    src = 0;
    word = '0;
    rdx = '0;
    hs_cnt = 0;
    cyc = 0;
    age = 0;
    rr = 1'($urandom_range(1));
    while (hs_cnt < 300 && cyc < 6000) begin
      cyc++;
      e0 = !infl && r0v && (!r1v || last);
      e1 = !infl && r1v && (!r0v || !last);
      chk("rnd_r0_ready", r0r, e0);
      chk("rnd_r1_ready", r1r, e1);
      hs = resv && rr;
      tick();
      if (e0 || e1) begin
        infl = 1;
        age = 0;
        word = e1 ? r1d : r0d;
        src = e1;
        last = e1;
      end else if (infl && !resv) begin
        age++;
        if (age == 1) begin
          resv = 1;
          rdx = ~word;
        end
      end else if (hs) begin
        resv = 0;
        infl = 0;
        hs_cnt++;
      end
      chk("rnd_rv", rv, resv);
      chk("rnd_rd", rd, rdx);
      chk("rnd_rs", rs, src);
      chk("rnd_din", din, word);
      chk("rnd_done", dc, hs_cnt % 256);
      chk("rnd_busy", busy, infl);
      keep = r0v && !e0;
      r0v = keep ? ($urandom_range(7) != 0) : 1'($urandom_range(1));
      if (!keep) r0d = 12'($urandom);
      keep = r1v && !e1;
      r1v = keep ? ($urandom_range(7) != 0) : 1'($urandom_range(1));
      if (!keep) r1d = 12'($urandom);
      rr = $urandom_range(3) != 0;
      #1;
    end
    chk("rnd_enough_txns", hs_cnt >= 300, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
